// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one iterative 4x4 multiplier core between two
// requesters; latches operands, starts the core, and returns products with timeout.
module mul_share_arbiter #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic [3:0]   a0,
  input  logic [3:0]   b0,
  input  logic         req1,
  input  logic [3:0]   a1,
  input  logic [3:0]   b1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [7:0]   z0,
  output logic [7:0]   z1,
  output logic         busy,
  output logic         gnt,
  output logic         mul_start,
  output logic [3:0]   mul_a,
  output logic [3:0]   mul_b,
  input  logic         mul_done,
  input  logic [7:0]   mul_z
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               grant_idx;

  // On a tie the requester that was not served last wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_idx = 1'b0;
    if (req0 && req1) grant_idx = ~gnt;
    else              grant_idx = req1;
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gnt       <= 1'b1;
      mul_a     <= 4'h0;
      mul_b     <= 4'h0;
      mul_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      z0        <= 8'h00;
      z1        <= 8'h00;
    end else begin
      mul_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt       <= grant_idx;
            mul_a     <= grant_idx ? a1 : a0;
            mul_b     <= grant_idx ? b1 : b0;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            if (gnt) z1 <= mul_z;
            else     z0 <= mul_z;
            done0 <= ~gnt;
            done1 <= gnt;
            state <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Timed out: the requester receives a zero product flagged with err.
            if (gnt) z1 <= 8'h00;
            else     z0 <= 8'h00;
            done0 <= ~gnt;
            done1 <= gnt;
            err   <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one iterative 4x4 unsigned multiplier core between two requesters (requester 0 and requester 1) using round-robin arbitration.
- Latches the granted requester's operands and issues a one-cycle start to the core.
- Waits for the core's done pulse, with a timeout, and returns the 8-bit product to the granted requester together with a one-cycle done pulse.
- Sits between the operand sources (switch inputs, test sequencer) and the multiplier core; its outputs feed the BCD conversion and seven-segment display path.

Parameters:
- TIMEOUT, default 32: maximum number of WAIT cycles allowed for mul_done before the operation is aborted with an error (range 2..255).
- CNT_W, default 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request level.
- a0  in  4  requester 0 multiplicand.
- b0  in  4  requester 0 multiplier.
- req1  in  1  requester 1 request level.
- a1  in  4  requester 1 multiplicand.
- b1  in  4  requester 1 multiplier.
- done0  out  1  one-cycle pulse: requester 0 result valid.
- done1  out  1  one-cycle pulse: requester 1 result valid.
- err  out  1  one-cycle pulse, coincident with the done pulse, when the operation timed out.
- z0  out  8  last product delivered to requester 0; held between deliveries.
- z1  out  8  last product delivered to requester 1; held between deliveries.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  index of the current or most recent grant.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a  out  4  latched operand to the core.
- mul_b  out  4  latched operand to the core.
- mul_done  in  1  core completion pulse.
- mul_z  in  8  core product; valid when mul_done=1.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; done0=done1=err=0; mul_start=0; busy=0; z0=z1=8'h00; mul_a=mul_b=0; gnt=1 so that requester 0 wins the first tie; timeout counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only reqN=1: grant N.
  - If both are high: grant the index not equal to gnt (round-robin).
  - On grant, at the edge: latch mul_a/mul_b from aN/bN, set gnt=N, go to ISSUE.
  - With no request, stay in IDLE.
  - Operands are sampled only at the grant edge; later changes to aN/bN have no effect on the operation in flight.
- ISSUE: mul_start=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - mul_done is sampled only in WAIT; a mul_done in IDLE, ISSUE or RESP is ignored.
  - mul_done=1: capture mul_z into z[gnt]; go to RESP with err_pending=0.
  - Otherwise increment the counter; when counter==TIMEOUT-1 and mul_done=0, write z[gnt]=8'h00 and go to RESP with err_pending=1.
- RESP:
  - done[gnt]=1 for one cycle; err=err_pending.
  - Go to IDLE; a new arbitration happens in the next IDLE cycle.
- Latency:
  - Request seen in IDLE at cycle t gives mul_start at t+1.
  - mul_done first seen at cycle d≥t+2 gives done at d+1.
  - With no contention, the minimum request-to-done latency is 3 cycles.
- Requester protocol:
  - reqN is a level. A requester still asserting reqN after its done pulse is treated as a new request and competes under round-robin.
  - Deasserting reqN before grant withdraws the request; deasserting after grant does not cancel the operation.
- z0/z1 change only in the WAIT→RESP transition for the granted index; the other requester's result is never disturbed.
- Arithmetic: unsigned; 15*15=225 (8'hE1) is the maximum; no truncation.
- Reset mid-operation: immediate return to IDLE with all reset values; no done pulse is issued for the aborted operation; a core pulse arriving after reset is ignored.

Test Plan:
- Single request: req0=1, a0=3, b0=5; core returns mul_done with mul_z=15 three cycles after start. Required: mul_start one cycle after the request, done0 one cycle after mul_done, z0=8'h0F, done1=0, err=0.
- Simultaneous requests: after reset, req0=req1=1, held high. Required: grants proceed 0,1,0,1 (gnt toggles), each preceded by its own mul_start; z0 and z1 each hold their own products.
- Maximum operands and operand change: a1=15, b1=15; aN/bN change during WAIT. Required: mul_a=mul_b=15 throughout the operation, z1=8'hE1.
- Timeout: core never asserts mul_done. Required: TIMEOUT WAIT cycles later, done pulse with err=1 and z[gnt]=8'h00; the next request proceeds normally.
- Stray done: mul_done pulsed while in IDLE. Required: no state change, no done pulse.
- Reset in WAIT: assert reset_n=0 while in WAIT, then release. Required: busy=0 immediately, no done pulse, z0=z1=0; the next request is granted to requester 0.
